// File: rtl/blob_track_pkg.sv
// Shared definitions for the blob tracking servo controller: FSM states,
// default parameter values, status LED bit positions and the slew helper.
package blob_track_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        SLEW   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [24:0] DEF_UPDATE_INTERVAL = 25'h08F0000;
    localparam int          DEF_DUTY_SHIFT      = 4;
    localparam logic [7:0]  DEF_DUTY_OFFSET     = 8'h01;
    localparam logic [7:0]  DEF_RESET_DUTY      = 8'h45;
    localparam logic [7:0]  DEF_MAX_STEP        = 8'h04;

    localparam int LED_BUSY    = 7;
    localparam int LED_SLEW    = 6;
    localparam int LED_REJ_MSB = 3;
    localparam int LED_REJ_LSB = 0;

    typedef struct packed {
        logic       limited;
        logic [7:0] duty;
    } slew_t;

    // Move cur toward tgt by at most step; never wraps because the limited
    // result always lies strictly between cur and tgt.
    function automatic slew_t slew_limit(input logic [7:0] cur,
                                         input logic [7:0] tgt,
                                         input logic [7:0] step);
        slew_t r;
        r.limited = 1'b0;
        r.duty    = tgt;
        if (tgt > cur) begin
            if ((tgt - cur) > step) begin
                r.limited = 1'b1;
                r.duty    = cur + step;
            end
        end else if ((cur - tgt) > step) begin
            r.limited = 1'b1;
            r.duty    = cur - step;
        end
        return r;
    endfunction

endpackage

// File: rtl/blob_track_ctrl_if.sv
// Bounding-box input handshake and servo/status outputs of blob_track_ctrl.
// master = box source (drives coordinates), slave = the controller.
interface blob_track_ctrl_if;

    logic [7:0] iXmin;
    logic [7:0] iXmax;
    logic [7:0] iYmin;
    logic [7:0] iYmax;
    logic       iNewCoord;
    logic       oReady;
    logic [7:0] oXduty;
    logic [7:0] oYduty;
    logic       oUpdate;
    logic [7:0] oLED;

    modport master (
        output iXmin, iXmax, iYmin, iYmax, iNewCoord,
        input  oReady, oXduty, oYduty, oUpdate, oLED
    );

    modport slave (
        input  iXmin, iXmax, iYmin, iYmax, iNewCoord,
        output oReady, oXduty, oYduty, oUpdate, oLED
    );

endinterface

// File: rtl/blob_center_calc.sv
// Combinational per-axis mapping from a min/max pixel pair to a servo duty:
// center of the span, scaled down by DUTY_SHIFT and biased by DUTY_OFFSET.
module blob_center_calc
    import blob_track_pkg::*;
#(
    parameter int         DUTY_SHIFT  = DEF_DUTY_SHIFT,
    parameter logic [7:0] DUTY_OFFSET = DEF_DUTY_OFFSET
) (
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    output logic [7:0] target
);

    logic [8:0] sum;
    logic [7:0] center;

    // Nine-bit sum keeps the carry so the midpoint of 255/255 stays 255.
    always_comb begin
        sum    = {1'b0, lo} + {1'b0, hi};
        center = 8'(sum >> 1);
        target = (center >> DUTY_SHIFT) + DUTY_OFFSET;
    end

endmodule

// File: rtl/blob_track_ctrl.sv
// Blob tracking servo controller: accepts a bounding box when ready, maps
// its center to X/Y servo duties over a fixed 3-cycle pipeline
// (CALC -> SLEW -> COMMIT) and enforces a minimum interval between commits.
// Slew limiting is compiled in only when BLOB_TRACK_SLEW_EN is defined.
module blob_track_ctrl
    import blob_track_pkg::*;
#(
    parameter logic [24:0] UPDATE_INTERVAL = DEF_UPDATE_INTERVAL,
    parameter int          DUTY_SHIFT      = DEF_DUTY_SHIFT,
    parameter logic [7:0]  DUTY_OFFSET     = DEF_DUTY_OFFSET,
    parameter logic [7:0]  RESET_DUTY      = DEF_RESET_DUTY,
    parameter logic [7:0]  MAX_STEP        = DEF_MAX_STEP
) (
    input  logic             iClock,
    input  logic             iReset,
    blob_track_ctrl_if.slave bus
);

`ifdef BLOB_TRACK_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    state_t      state;
    state_t      state_next;
    logic        ready;
    logic        accept;
    logic        box_ok;

    logic [24:0] interval_cnt;
    logic        interval_done;

    logic [7:0]  box_xmin;
    logic [7:0]  box_xmax;
    logic [7:0]  box_ymin;
    logic [7:0]  box_ymax;
    logic [7:0]  calc_x;
    logic [7:0]  calc_y;
    logic [7:0]  tgt_x;
    logic [7:0]  tgt_y;
    slew_t       step_x;
    slew_t       step_y;
    logic [7:0]  next_x;
    logic [7:0]  next_y;
    logic        limited_x;
    logic        limited_y;

    logic [7:0]  duty_x;
    logic [7:0]  duty_y;
    logic        update_pulse;
    logic        slew_flag;
    logic [3:0]  reject_cnt;
    logic [7:0]  led;

    assign interval_done = (interval_cnt == UPDATE_INTERVAL);
    assign box_ok        = (bus.iXmin <= bus.iXmax) && (bus.iYmin <= bus.iYmax);
    assign accept        = ready && bus.iNewCoord;

    blob_center_calc #(
        .DUTY_SHIFT  (DUTY_SHIFT),
        .DUTY_OFFSET (DUTY_OFFSET)
    ) u_center_x (
        .lo     (box_xmin),
        .hi     (box_xmax),
        .target (calc_x)
    );

    blob_center_calc #(
        .DUTY_SHIFT  (DUTY_SHIFT),
        .DUTY_OFFSET (DUTY_OFFSET)
    ) u_center_y (
        .lo     (box_ymin),
        .hi     (box_ymax),
        .target (calc_y)
    );

    // FSM state register; reset always wins over a same-edge handshake.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge iClock) begin
        if (iReset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and ready decode; a rejected box leaves the FSM in IDLE.
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = interval_done;
                if (ready && bus.iNewCoord && box_ok) state_next = CALC;
            end
            CALC:    state_next = SLEW;
            SLEW:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-axis slew step toward the target; pass-through when not compiled in.
    always_comb begin
        step_x = '{limited: 1'b0, duty: tgt_x};
        step_y = '{limited: 1'b0, duty: tgt_y};
        if (SLEW_EN) begin
            step_x = slew_limit(duty_x, tgt_x, MAX_STEP);
            step_y = slew_limit(duty_y, tgt_y, MAX_STEP);
        end
    end

    // Pipeline datapath: captured box, targets and slewed duties.
    // NOTE: these stages are always loaded before being consumed, so they
    // carry no reset; only architecturally visible state is reset.
    always_ff @(posedge iClock) begin
        if (accept && box_ok) begin
            box_xmin <= bus.iXmin;
            box_xmax <= bus.iXmax;
            box_ymin <= bus.iYmin;
            box_ymax <= bus.iYmax;
        end
        if (state == CALC) begin
            tgt_x <= calc_x;
            tgt_y <= calc_y;
        end
        if (state == SLEW) begin
            next_x    <= step_x.duty;
            next_y    <= step_y.duty;
            limited_x <= step_x.limited;
            limited_y <= step_y.limited;
        end
    end

    // Visible state: duties, update pulse, status flags and interval counter.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            duty_x       <= RESET_DUTY;
            duty_y       <= RESET_DUTY;
            update_pulse <= 1'b0;
            slew_flag    <= 1'b0;
            reject_cnt   <= 4'h0;
            interval_cnt <= UPDATE_INTERVAL;
        end else begin
            update_pulse <= 1'b0;
            if (!interval_done) interval_cnt <= interval_cnt + 25'd1;
            if (accept && !box_ok && reject_cnt != 4'hF) reject_cnt <= reject_cnt + 4'd1;
            if (state == COMMIT) begin
                duty_x       <= next_x;
                duty_y       <= next_y;
                update_pulse <= 1'b1;
                slew_flag    <= limited_x | limited_y;
                interval_cnt <= 25'd0;
            end
        end
    end

    // Status LED assembly.
    always_comb begin
        led                          = 8'h00;
        led[LED_BUSY]                = (state != IDLE);
        led[LED_SLEW]                = slew_flag;
        led[LED_REJ_MSB:LED_REJ_LSB] = reject_cnt;
    end

    assign bus.oReady  = ready;
    assign bus.oXduty  = duty_x;
    assign bus.oYduty  = duty_y;
    assign bus.oUpdate = update_pulse;
    assign bus.oLED    = led;

endmodule

// File: doc/blob_track_ctrl.md
BLOB_TRACK_CTRL -- requirements
Module: blob_track_ctrl

Interface
REQ-001 SHALL have parameter UPDATE_INTERVAL, default 25'h08F0000, minimum clocks from one commit to the next accepted coordinate.
REQ-002 SHALL have parameter DUTY_SHIFT, default 4, right-shift that maps the pixel center to the duty.
REQ-003 SHALL have parameter DUTY_OFFSET, default 8'h01, added to the shifted center.
REQ-004 SHALL have parameter RESET_DUTY, default 8'h45, duty value at reset.
REQ-005 SHALL have parameter MAX_STEP, default 8'h04, maximum duty change per update when slew limiting is compiled in.
REQ-006 SHALL have port iClock, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port iReset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports iXmin/iXmax/iYmin/iYmax, input, 8 each, blob bounding box.
REQ-009 SHALL have port iNewCoord, input, 1, box valid.
REQ-010 SHALL have port oReady, output, 1, box accepted when iNewCoord and oReady are both high at an edge.
REQ-011 SHALL have ports oXduty/oYduty, output, 8 each, registered servo duty commands.
REQ-012 SHALL have port oUpdate, output, 1, one-cycle pulse when the duties change.
REQ-013 SHALL have port oLED, output, 8, status: [7] busy (not IDLE), [6] last commit was slew-limited, [5:4] 0, [3:0] rejected-box count.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, SLEW, COMMIT; IDLE->CALC on handshake, CALC->SLEW, SLEW->COMMIT, COMMIT->IDLE, unconditionally.
REQ-015 SHALL drive oReady high only in IDLE with the interval counter expired; no input buffering; iNewCoord while oReady is low is dropped.
REQ-016 SHALL, on handshake, register all four inputs; later input changes have no effect on that update.
REQ-017 SHALL reject a box with iXmin>iXmax or iYmin>iYmax: stay in IDLE, leave duties unchanged, no oUpdate, increment oLED[3:0] saturating at 4'hF, leave the interval counter untouched.
REQ-018 SHALL compute in CALC: 9-bit sum min+max, center = sum[8:1], target = (center >> DUTY_SHIFT) + DUTY_OFFSET, truncated to 8 bits; X and Y in parallel.
REQ-019 SHALL in SLEW: without slew limiting, next = target; with it, next = target if |target-current| <= MAX_STEP, else current ± MAX_STEP toward target, with no wrap.
REQ-020 SHALL in COMMIT load oXduty/oYduty, pulse oUpdate for exactly one cycle, set oLED[6] if either axis was limited, and restart the interval counter at 0.
REQ-021 SHALL make the latency from handshake at edge N to new duties and oUpdate visible after edge N+3; oUpdate high only for the cycle after N+3.
REQ-022 SHALL saturate the interval counter at UPDATE_INTERVAL; expired means count == UPDATE_INTERVAL; UPDATE_INTERVAL=0 gives oReady on every IDLE cycle.
REQ-023 SHALL hold duties constant between commits; an equal-value commit still pulses oUpdate.

Reset
REQ-024 SHALL on iReset set oXduty=oYduty=RESET_DUTY, oUpdate=0, oLED=8'h00, state IDLE, and the interval counter expired (oReady=1 in the first cycle after reset).
REQ-025 SHALL, on reset asserted mid-update (CALC/SLEW/COMMIT), abandon the update with no oUpdate pulse; reset wins over any same-edge handshake.

Configuration
REQ-026 SHALL compile slew limiting (REQ-019, oLED[6]) only when macro BLOB_TRACK_SLEW_EN is defined; without it, SLEW passes target through, oLED[6]=0, and latency remains 3 cycles.

Structure
REQ-027 SHALL take the FSM state enum, the default parameter constants and the oLED bit indices from shared package blob_track_pkg.
REQ-028 SHALL place the REQ-018 arithmetic in a combinational sub-module blob_center_calc, instantiated once per axis.

Verification
REQ-029 SHALL check reset: after iReset, oXduty=oYduty=8'h45, oReady=1, oLED=8'h00.
REQ-030 SHALL check, with slew off and interval 16: X 8'h20..8'h60 and Y 8'hFF..8'hFF; expect oXduty=8'h05 and oYduty=8'h10 after 3 edges, one oUpdate pulse, and oReady low for 16 cycles.
REQ-031 SHALL check, with BLOB_TRACK_SLEW_EN: the REQ-030 X box from 8'h45 gives oXduty=8'h41, 8'h3D, ... on repeated commits, with oLED[6]=1 until within 4.
REQ-032 SHALL check a box with iXmin=8'h50, iXmax=8'h10: no oUpdate, duties unchanged, oLED[3:0] increments; the 16th and later rejects hold 4'hF.
REQ-033 SHALL check iReset asserted during SLEW: no oUpdate pulse, duties back to 8'h45, and the next valid box is accepted immediately.
REQ-034 SHALL check iNewCoord held high through the interval: exactly one acceptance per UPDATE_INTERVAL+4 cycles.
